// File: rtl/ctrl_pipe_regs.sv
// Control-word pipeline: carries a control word and valid bit through STAGES registers
// with per-stage stall/flush, bubble insertion, backward stall propagation and event counters.
module ctrl_pipe_regs #(
  parameter int                 WIDTH       = 24,
  parameter int                 STAGES      = 3,
  parameter logic [WIDTH-1:0]   CLEAR_VALUE = '0,
  parameter int                 CNT_W       = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [WIDTH-1:0]          i_word,
  input  logic                      i_valid,
  input  logic [STAGES-1:0]         i_stall,
  input  logic [STAGES-1:0]         i_flush,
  input  logic                      i_cnt_clr,
  output logic [STAGES*WIDTH-1:0]   o_word,
  output logic [STAGES-1:0]         o_valid,
  output logic [STAGES-1:0]         o_hold,
  output logic [CNT_W-1:0]          o_stall_cnt,
  output logic [CNT_W-1:0]          o_bubble_cnt,
  output logic [CNT_W-1:0]          o_flush_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [STAGES-1:0] bubble;
  logic              any_stall;
  logic              any_bubble;
  logic              flush_hit;

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] up_word;
      logic             up_valid;
      logic [WIDTH-1:0] stage_word;
      logic             stage_vld;

      // A stall at stage k or any later stage freezes stage k.
      assign o_hold[k] = |i_stall[STAGES-1:k];

      if (k == 0) begin : g_head
        // Invalid input is normalised so valid=0 always pairs with CLEAR_VALUE.
        assign up_word   = i_valid ? i_word : CLEAR_VALUE;
        assign up_valid  = i_valid;
        assign bubble[k] = 1'b0;
      end else begin : g_body
        assign up_word   = o_word[(k-1)*WIDTH +: WIDTH];
        assign up_valid  = o_valid[k-1];
        assign bubble[k] = !i_flush[k] && !o_hold[k] && o_hold[k-1];
      end

      always_ff @(posedge i_clk) begin
        if (i_rst || i_flush[k]) begin
          stage_word <= CLEAR_VALUE;
          stage_vld  <= 1'b0;
        end else if (o_hold[k]) begin
          stage_word <= stage_word;
          stage_vld  <= stage_vld;
        end else if (bubble[k]) begin
          stage_word <= CLEAR_VALUE;
          stage_vld  <= 1'b0;
        end else begin
          stage_word <= up_word;
          stage_vld  <= up_valid;
        end
      end

      assign o_word[k*WIDTH +: WIDTH] = stage_word;
      assign o_valid[k]               = stage_vld;
    end
  endgenerate

  // Event detection for the counters, all from the current cycle's inputs and state.
  assign any_stall  = |i_stall;
  assign any_bubble = |bubble;
  assign flush_hit  = |(i_flush & o_valid);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_cnt_clr) begin
      o_stall_cnt  <= '0;
      o_bubble_cnt <= '0;
      o_flush_cnt  <= '0;
    end else begin
      if (any_stall)  o_stall_cnt  <= sat_inc(o_stall_cnt);
      if (any_bubble) o_bubble_cnt <= sat_inc(o_bubble_cnt);
      if (flush_hit)  o_flush_cnt  <= sat_inc(o_flush_cnt);
    end
  end

endmodule

// File: tb/tb_ctrl_pipe_regs.sv
// Table-driven bench for ctrl_pipe_regs (WIDTH=8, STAGES=3, CNT_W=4) with a hand-written
// stall-counter saturation sequence.
module tb_ctrl_pipe_regs;
  localparam int WIDTH  = 8;
  localparam int STAGES = 3;
  localparam int CNT_W  = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [WIDTH-1:0]        word;
  logic                    valid;
  logic [STAGES-1:0]       stall;
  logic [STAGES-1:0]       flush;
  logic                    cnt_clr;
  logic [STAGES*WIDTH-1:0] o_word;
  logic [STAGES-1:0]       o_valid;
  logic [STAGES-1:0]       o_hold;
  logic [CNT_W-1:0]        o_stall_cnt;
  logic [CNT_W-1:0]        o_bubble_cnt;
  logic [CNT_W-1:0]        o_flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ctrl_pipe_regs #(
    .WIDTH(WIDTH), .STAGES(STAGES), .CLEAR_VALUE(8'h00), .CNT_W(CNT_W)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_word(word), .i_valid(valid),
    .i_stall(stall), .i_flush(flush), .i_cnt_clr(cnt_clr),
    .o_word(o_word), .o_valid(o_valid), .o_hold(o_hold),
    .o_stall_cnt(o_stall_cnt), .o_bubble_cnt(o_bubble_cnt), .o_flush_cnt(o_flush_cnt)
  );

  typedef struct {
    logic        rst;
    logic [7:0]  word;
    logic        valid;
    logic [2:0]  stall;
    logic [2:0]  flush;
    logic        clr;
    logic [23:0] e_word;
    logic [2:0]  e_valid;
    logic [2:0]  e_hold;
    logic [3:0]  e_stall;
    logic [3:0]  e_bubble;
    logic [3:0]  e_flush;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(logic r, logic [7:0] w, logic v, logic [2:0] s, logic [2:0] f,
                              logic c, logic [23:0] ew, logic [2:0] ev, logic [2:0] eh,
                              logic [3:0] es, logic [3:0] eb, logic [3:0] ef);
    vec_t t;
    t.rst = r; t.word = w; t.valid = v; t.stall = s; t.flush = f; t.clr = c;
    t.e_word = ew; t.e_valid = ev; t.e_hold = eh;
    t.e_stall = es; t.e_bubble = eb; t.e_flush = ef;
    return t;
  endfunction

  task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(logic r, logic [7:0] w, logic v, logic [2:0] s, logic [2:0] f, logic c);
    rst = r; word = w; valid = v; stall = s; flush = f; cnt_clr = c;
  endtask

  task automatic run_row(int i);
    drive(tbl[i].rst, tbl[i].word, tbl[i].valid, tbl[i].stall, tbl[i].flush, tbl[i].clr);
    @(posedge clk);
    #1;
    check("word",   i, 32'(o_word),       32'(tbl[i].e_word));
    check("valid",  i, 32'(o_valid),      32'(tbl[i].e_valid));
    check("hold",   i, 32'(o_hold),       32'(tbl[i].e_hold));
    check("stall",  i, 32'(o_stall_cnt),  32'(tbl[i].e_stall));
    check("bubble", i, 32'(o_bubble_cnt), 32'(tbl[i].e_bubble));
    check("flush",  i, 32'(o_flush_cnt),  32'(tbl[i].e_flush));
  endtask

  initial begin
    // o_word is {stage2, stage1, stage0}.
    tbl[0]  = mk(1, 8'h00, 0, 3'b000, 3'b000, 0, 24'h000000, 3'b000, 3'b000, 0, 0, 0);
    tbl[1]  = mk(0, 8'h11, 1, 3'b000, 3'b000, 0, 24'h000011, 3'b001, 3'b000, 0, 0, 0);
    tbl[2]  = mk(0, 8'h22, 1, 3'b000, 3'b000, 0, 24'h001122, 3'b011, 3'b000, 0, 0, 0);
    tbl[3]  = mk(0, 8'h33, 1, 3'b000, 3'b000, 0, 24'h112233, 3'b111, 3'b000, 0, 0, 0);
    tbl[4]  = mk(0, 8'h22, 1, 3'b000, 3'b000, 0, 24'h223322, 3'b111, 3'b000, 0, 0, 0);
    tbl[5]  = mk(0, 8'h11, 1, 3'b000, 3'b000, 0, 24'h332211, 3'b111, 3'b000, 0, 0, 0);
    tbl[6]  = mk(0, 8'h55, 1, 3'b010, 3'b000, 0, 24'h002211, 3'b011, 3'b011, 1, 1, 0);
    tbl[7]  = mk(0, 8'h66, 1, 3'b001, 3'b001, 0, 24'h220000, 3'b100, 3'b001, 2, 2, 1);
    tbl[8]  = mk(0, 8'h77, 1, 3'b000, 3'b000, 0, 24'h000077, 3'b001, 3'b000, 2, 2, 1);
    tbl[9]  = mk(0, 8'hFF, 0, 3'b000, 3'b000, 0, 24'h007700, 3'b010, 3'b000, 2, 2, 1);
    tbl[10] = mk(0, 8'h88, 1, 3'b000, 3'b001, 0, 24'h770000, 3'b100, 3'b000, 2, 2, 1);
    tbl[11] = mk(0, 8'h99, 1, 3'b000, 3'b100, 0, 24'h000099, 3'b001, 3'b000, 2, 2, 2);
    tbl[12] = mk(0, 8'h00, 0, 3'b100, 3'b000, 1, 24'h000099, 3'b001, 3'b111, 0, 0, 0);
    tbl[13] = mk(0, 8'h00, 0, 3'b010, 3'b000, 0, 24'h000099, 3'b001, 3'b011, 1, 1, 0);
    tbl[14] = mk(0, 8'hAA, 1, 3'b000, 3'b000, 0, 24'h0099AA, 3'b011, 3'b000, 1, 1, 0);
    tbl[15] = mk(0, 8'hBB, 1, 3'b000, 3'b000, 0, 24'h99AABB, 3'b111, 3'b000, 1, 1, 0);
    tbl[16] = mk(1, 8'hCC, 1, 3'b111, 3'b010, 0, 24'h000000, 3'b000, 3'b111, 0, 0, 0);
    tbl[17] = mk(0, 8'hAA, 1, 3'b000, 3'b000, 0, 24'h0000AA, 3'b001, 3'b000, 0, 0, 0);
    tbl[18] = mk(0, 8'hBB, 1, 3'b000, 3'b000, 0, 24'h00AABB, 3'b011, 3'b000, 0, 0, 0);
    tbl[19] = mk(0, 8'hCC, 1, 3'b111, 3'b111, 0, 24'h000000, 3'b000, 3'b111, 1, 0, 1);
    tbl[20] = mk(0, 8'hDD, 1, 3'b000, 3'b000, 0, 24'h0000DD, 3'b001, 3'b000, 1, 0, 1);

    drive(1, 8'h00, 0, 3'b000, 3'b000, 0);
    @(negedge clk);

    for (int i = 0; i <= 11; i++) run_row(i);

    // Long stall at the last stage: everything frozen, stall counter saturates at 0xF.
    for (int i = 0; i < 20; i++) begin
      drive(0, 8'h00, 0, 3'b100, 3'b000, 0);
      @(posedge clk);
      #1;
      check("stall_sat", i, 32'(o_stall_cnt), (3 + i > 15) ? 32'd15 : 32'(3 + i));
    end
    check("sat_word",   99, 32'(o_word),       32'h000099);
    check("sat_valid",  99, 32'(o_valid),      32'h1);
    check("sat_bubble", 99, 32'(o_bubble_cnt), 32'h2);
    check("sat_flush",  99, 32'(o_flush_cnt),  32'h2);

    for (int i = 12; i <= 20; i++) run_row(i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
